memory_controller: RTL and testbench

Three-port arbitrated front end to a single-ported 256×8 on-chip SRAM. Three independent devices issue read or write requests in parallel; a round-robin arbiter grants one device per clock, performs its access, and returns a one-hot acknowledge plus the data. It sits between the device masters and the shared memory. No device can starve while others keep requesting.

---
 rtl/memory_controller_pkg.sv | 34 +++
 rtl/memory_controller_rr_arbiter3.sv | 88 ++++++++
 rtl/memory_controller.sv | 107 ++++++++++
 tb/tb_memory_controller.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/memory_controller_pkg.sv
// -----------------------------------------------------------------------------
// memory_controller_pkg
// Shared constants and types for the three-port arbitrated SRAM front end.
//   C_DATA_WIDTH / C_ADDR_WIDTH / C_DEPTH : default data, address and depth
//   N_DEVICES                             : number of requesting devices (3)
//   dev_idx_t                             : device index (device 1..3 -> 0..2)
//   dev_onehot()                          : index -> one-hot grant/ack vector
// -----------------------------------------------------------------------------
package memory_controller_pkg;

    localparam int C_DATA_WIDTH = 8;
    localparam int C_ADDR_WIDTH = 8;
    localparam int C_DEPTH      = 256;
    localparam int N_DEVICES    = 3;

    typedef enum logic [1:0] {
        DEV_1 = 2'd0,
        DEV_2 = 2'd1,
        DEV_3 = 2'd2
    } dev_idx_t;

    // Convert a device index into its one-hot request/ack position.
    function automatic logic [N_DEVICES-1:0] dev_onehot(input dev_idx_t idx);
        logic [N_DEVICES-1:0] v;
        case (idx)
            DEV_1:   v = 3'b001;
            DEV_2:   v = 3'b010;
            DEV_3:   v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/memory_controller_rr_arbiter3.sv
// -----------------------------------------------------------------------------
// rr_arbiter3
// Three-way round-robin arbiter. The search starts at the device after the
// last one granted; the last-granted pointer only moves when a grant is made.
// Grant is combinational from the current requests so the top can perform the
// access on the same edge.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset (pointer -> device 3)
//   i_req    : request vector, bit i = device i+1
//   o_grant  : one-hot grant, 000 when nothing is requested
// -----------------------------------------------------------------------------
module rr_arbiter3
    import memory_controller_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_DEVICES-1:0] i_req,
    output logic [N_DEVICES-1:0] o_grant
);

    dev_idx_t r_last;
    dev_idx_t w_next;
    logic     w_found;

    // Rotating priority search starting after the last granted device.
    always_comb begin
        w_next  = r_last;
        w_found = 1'b0;
        case (r_last)
            DEV_1: begin
                if (i_req[1]) begin
                    w_next = DEV_2; w_found = 1'b1;
                end else if (i_req[2]) begin
                    w_next = DEV_3; w_found = 1'b1;
                end else if (i_req[0]) begin
                    w_next = DEV_1; w_found = 1'b1;
                end else begin
                    w_next = r_last; w_found = 1'b0;
                end
            end
            DEV_2: begin
                if (i_req[2]) begin
                    w_next = DEV_3; w_found = 1'b1;
                end else if (i_req[0]) begin
                    w_next = DEV_1; w_found = 1'b1;
                end else if (i_req[1]) begin
                    w_next = DEV_2; w_found = 1'b1;
                end else begin
                    w_next = r_last; w_found = 1'b0;
                end
            end
            // DEV_3 and the unused encoding both restart the order at device 1.
            default: begin
                if (i_req[0]) begin
                    w_next = DEV_1; w_found = 1'b1;
                end else if (i_req[1]) begin
                    w_next = DEV_2; w_found = 1'b1;
                end else if (i_req[2]) begin
                    w_next = DEV_3; w_found = 1'b1;
                end else begin
                    w_next = r_last; w_found = 1'b0;
                end
            end
        endcase
    end

    // Grant vector derived from the search result.
    always_comb begin
        if (w_found) begin
            o_grant = dev_onehot(w_next);
        end else begin
            o_grant = 3'b000;
        end
    end

    // Last-granted pointer; reset to device 3 so device 1 wins first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= DEV_3;
        end else if (w_found) begin
            r_last <= w_next;
        end else begin
            r_last <= r_last;
        end
    end

endmodule

// File: rtl/memory_controller.sv
// -----------------------------------------------------------------------------
// memory_controller
// Three-port round-robin front end to a single-ported DEPTH x DATA_WIDTH SRAM.
// One device is served per clock; its access completes at the grant edge and
// the one-hot ack plus data are valid for the following cycle.
// Ports:
//   clk                  : clock, rising edge
//   reset                : asynchronous active-low reset
//   devices_mem_en       : bit i = device i+1 requests an access
//   device_N_mem_addr    : device N address
//   device_N_mem_di      : device N write data
//   devices_mem_we       : bit i = device i+1 access is a write
//   devices_do_ack       : one-hot, transaction of device i+1 completed
//   mem_do               : read data, or echoed write data, of that transaction
// -----------------------------------------------------------------------------
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int ADDR_WIDTH = C_ADDR_WIDTH,
    parameter int DEPTH      = C_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_DEVICES-1:0]  devices_mem_en,
    input  logic [ADDR_WIDTH-1:0] device_1_mem_addr,
    input  logic [ADDR_WIDTH-1:0] device_2_mem_addr,
    input  logic [ADDR_WIDTH-1:0] device_3_mem_addr,
    input  logic [DATA_WIDTH-1:0] device_1_mem_di,
    input  logic [DATA_WIDTH-1:0] device_2_mem_di,
    input  logic [DATA_WIDTH-1:0] device_3_mem_di,
    input  logic [N_DEVICES-1:0]  devices_mem_we,
    output logic [N_DEVICES-1:0]  devices_do_ack,
    output logic [DATA_WIDTH-1:0] mem_do
);

    logic [N_DEVICES-1:0]  w_grant;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_di;
    logic                  w_we;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [N_DEVICES-1:0]  r_ack;
    logic [DATA_WIDTH-1:0] r_do;

    rr_arbiter3 u_arbiter (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_req   (devices_mem_en),
        .o_grant (w_grant)
    );

    // Route the granted device's address, data and write strobe to the SRAM.
    always_comb begin
        w_addr = {ADDR_WIDTH{1'b0}};
        w_di   = {DATA_WIDTH{1'b0}};
        w_we   = 1'b0;
        case (w_grant)
            3'b001: begin
                w_addr = device_1_mem_addr;
                w_di   = device_1_mem_di;
                w_we   = devices_mem_we[0];
            end
            3'b010: begin
                w_addr = device_2_mem_addr;
                w_di   = device_2_mem_di;
                w_we   = devices_mem_we[1];
            end
            3'b100: begin
                w_addr = device_3_mem_addr;
                w_di   = device_3_mem_di;
                w_we   = devices_mem_we[2];
            end
            default: begin
                w_addr = {ADDR_WIDTH{1'b0}};
                w_di   = {DATA_WIDTH{1'b0}};
                w_we   = 1'b0;
            end
        endcase
    end

    // SRAM write port; contents are not reset. A write coinciding with an
    // asserted reset is dropped.
    always_ff @(posedge clk) begin
        if (reset && w_we) begin
            r_mem[w_addr] <= w_di;
        end
    end

    // Ack and read-data registers; mem_do holds when nobody is granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ack <= 3'b000;
            r_do  <= {DATA_WIDTH{1'b0}};
        end else if (|w_grant) begin
            r_ack <= w_grant;
            r_do  <= w_we ? w_di : r_mem[w_addr];
        end else begin
            r_ack <= 3'b000;
            r_do  <= r_do;
        end
    end

    assign devices_do_ack = r_ack;
    assign mem_do         = r_do;

endmodule

// File: tb/tb_memory_controller.sv
// -----------------------------------------------------------------------------
// tb_memory_controller
// Table-driven bench with a scoreboard queue of expected {ack, data} results,
// plus hand-written reset sequences.
// -----------------------------------------------------------------------------
module tb_memory_controller;

    logic       clk;
    logic       reset;
    logic [2:0] devices_mem_en;
    logic [7:0] device_1_mem_addr, device_2_mem_addr, device_3_mem_addr;
    logic [7:0] device_1_mem_di, device_2_mem_di, device_3_mem_di;
    logic [2:0] devices_mem_we;
    logic [2:0] devices_do_ack;
    logic [7:0] mem_do;

    memory_controller dut (
        .clk               (clk),
        .reset             (reset),
        .devices_mem_en    (devices_mem_en),
        .device_1_mem_addr (device_1_mem_addr),
        .device_2_mem_addr (device_2_mem_addr),
        .device_3_mem_addr (device_3_mem_addr),
        .device_1_mem_di   (device_1_mem_di),
        .device_2_mem_di   (device_2_mem_di),
        .device_3_mem_di   (device_3_mem_di),
        .devices_mem_we    (devices_mem_we),
        .devices_do_ack    (devices_do_ack),
        .mem_do            (mem_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] en;
        logic [2:0] we;
        logic [7:0] a1, a2, a3;
        logic [7:0] d1, d2, d3;
        logic [2:0] ack;
        logic [7:0] dout;
    } vec_t;

    typedef struct {
        string      name;
        logic [2:0] ack;
        logic [7:0] dout;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input string name, input logic [2:0] en, input logic [2:0] we,
                       input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3,
                       input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3,
                       input logic [2:0] ack, input logic [7:0] dout);
        vec_t v;
        v.name = name; v.en = en; v.we = we;
        v.a1 = a1; v.a2 = a2; v.a3 = a3;
        v.d1 = d1; v.d2 = d2; v.d3 = d3;
        v.ack = ack; v.dout = dout;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        devices_mem_en    = v.en;
        devices_mem_we    = v.we;
        device_1_mem_addr = v.a1;
        device_2_mem_addr = v.a2;
        device_3_mem_addr = v.a3;
        device_1_mem_di   = v.d1;
        device_2_mem_di   = v.d2;
        device_3_mem_di   = v.d3;
    endtask

    // Drive one vector, push its expectation, clock once and compare.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        drive(v);
        e.name = v.name; e.ack = v.ack; e.dout = v.dout;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            got = sb.pop_front();
            check({got.name, "_ack"}, {5'b00000, devices_do_ack}, {5'b00000, got.ack});
            check({got.name, "_do"}, mem_do, got.dout);
        end
    endtask

    initial begin
        // Parallel write then rotation repeat.
        add("wr1", 3'b111, 3'b111, 8'h0A, 8'h0B, 8'h0C, 8'h42, 8'h43, 8'h44, 3'b001, 8'h42);
        add("wr2", 3'b111, 3'b111, 8'h0A, 8'h0B, 8'h0C, 8'h42, 8'h43, 8'h44, 3'b010, 8'h43);
        add("wr3", 3'b111, 3'b111, 8'h0A, 8'h0B, 8'h0C, 8'h42, 8'h43, 8'h44, 3'b100, 8'h44);
        add("wr4", 3'b111, 3'b111, 8'h0A, 8'h0B, 8'h0C, 8'h42, 8'h43, 8'h44, 3'b001, 8'h42);
        add("wr5", 3'b111, 3'b111, 8'h0A, 8'h0B, 8'h0C, 8'h42, 8'h43, 8'h44, 3'b010, 8'h43);
        add("wr6", 3'b111, 3'b111, 8'h0A, 8'h0B, 8'h0C, 8'h42, 8'h43, 8'h44, 3'b100, 8'h44);
        // Single-device readback, served every cycle.
        add("rd1a", 3'b001, 3'b000, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'b001, 8'h42);
        add("rd1b", 3'b001, 3'b000, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'b001, 8'h42);
        add("rd2a", 3'b010, 3'b000, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 3'b010, 8'h43);
        add("rd2b", 3'b010, 3'b000, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 3'b010, 8'h43);
        add("rd3a", 3'b100, 3'b000, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 3'b100, 8'h44);
        add("rd3b", 3'b100, 3'b000, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 3'b100, 8'h44);
        // All reading, then device 2 drops out: 1 and 3 alternate.
        add("all1", 3'b111, 3'b000, 8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 3'b001, 8'h42);
        add("all2", 3'b111, 3'b000, 8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 3'b010, 8'h43);
        add("all3", 3'b111, 3'b000, 8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 3'b100, 8'h44);
        add("drp1", 3'b101, 3'b000, 8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 3'b001, 8'h42);
        add("drp2", 3'b101, 3'b000, 8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 3'b100, 8'h44);
        add("drp3", 3'b101, 3'b000, 8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 3'b001, 8'h42);
        add("drp4", 3'b101, 3'b000, 8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 3'b100, 8'h44);
        // Idle: no ack, data holds.
        add("idl1", 3'b000, 3'b111, 8'h0A, 8'h0B, 8'h0C, 8'hEE, 8'hEE, 8'hEE, 3'b000, 8'h44);
        add("idl2", 3'b000, 3'b111, 8'h0A, 8'h0B, 8'h0C, 8'hEE, 8'hEE, 8'hEE, 3'b000, 8'h44);
        add("idl3", 3'b000, 3'b000, 8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 3'b000, 8'h44);
        // Read-after-write to the same address by different devices.
        add("raw1", 3'b011, 3'b001, 8'h20, 8'h20, 8'h00, 8'h5A, 8'h00, 8'h00, 3'b001, 8'h5A);
        add("raw2", 3'b011, 3'b001, 8'h20, 8'h20, 8'h00, 8'h5A, 8'h00, 8'h00, 3'b010, 8'h5A);
        // we bits of non-requesting devices have no effect.
        add("wei1", 3'b001, 3'b110, 8'h0A, 8'h0B, 8'h0C, 8'h99, 8'h99, 8'h99, 3'b001, 8'h42);
        add("wei2", 3'b010, 3'b000, 8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 3'b010, 8'h43);
        // Pointer now at device 2, so device 3 goes next.
        add("pre", 3'b111, 3'b000, 8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 3'b100, 8'h44);

        // Reset held low with all devices requesting writes.
        reset = 1'b0;
        devices_mem_en = 3'b111; devices_mem_we = 3'b111;
        device_1_mem_addr = 8'h0A; device_2_mem_addr = 8'h0B; device_3_mem_addr = 8'h0C;
        device_1_mem_di = 8'hF1; device_2_mem_di = 8'hF2; device_3_mem_di = 8'hF3;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {5'b00000, devices_do_ack}, 8'h00);
        check("rst_do", mem_do, 8'h00);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        // Asynchronous reset between edges clears outputs at once.
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_ack", {5'b00000, devices_do_ack}, 8'h00);
        check("mid_rst_do", mem_do, 8'h00);
        drive('{"x", 3'b111, 3'b111, 8'h0A, 8'h0B, 8'h0C, 8'hFF, 8'hFF, 8'hFF, 3'b000, 8'h00});
        repeat (2) @(posedge clk);
        #1;
        check("hold_rst_ack", {5'b00000, devices_do_ack}, 8'h00);
        check("hold_rst_do", mem_do, 8'h00);
        reset = 1'b1;

        // Order restarts at device 1; writes during reset were dropped.
        step('{"post1", 3'b111, 3'b000, 8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 3'b001, 8'h42});
        step('{"post2", 3'b111, 3'b000, 8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 3'b010, 8'h43});
        step('{"post3", 3'b111, 3'b000, 8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 3'b100, 8'h44});
        step('{"post4", 3'b111, 3'b000, 8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 3'b001, 8'h42});

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
